univ_shift_reg: RTL and testbench

Parametrised universal shift register: a WIDTH-bit bank of edge-triggered storage cells with asynchronous active-low reset, synchronous clear, clock enable, parallel load, and left/right shift with optional rotate. It generalises the team's single-bit D storage element to a multi-bit register with selectable modes. It is the storage primitive for serial/parallel converters, counters and datapath registers in the ATV series.

---
 rtl/univ_shift_reg.sv | 84 ++++++++
 tb/tb_univ_shift_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register.
// WIDTH-bit register with async active-low reset to RST_VAL, synchronous
// clear, clock enable, and modes hold / shift right / shift left / parallel
// load. Shifts can rotate, and rotating ignores the serial inputs.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (q <= RST_VAL)
//   clr     synchronous clear (q <= 0); overrides en and mode
//   en      clock enable; low holds q
//   mode    00 hold, 01 shift right, 10 shift left, 11 parallel load
//   rot     1: shifts are circular, serial inputs ignored
//   sin_r   serial input entering at q[WIDTH-1] on a right shift
//   sin_l   serial input entering at q[0] on a left shift
//   d       parallel load data
//   q       register contents
//   sout_r  q[0], the bit leaving on the next right shift (combinational)
//   sout_l  q[WIDTH-1], the bit leaving on the next left shift (combinational)
module univ_shift_reg #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // Shifting needs at least two cells; 32 bits is the supported ceiling.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("univ_shift_reg: WIDTH must be in 2..32");
    end

    logic [WIDTH-1:0] q_nxt;
    logic             shr_in;
    logic             shl_in;

    // Bits entering the vacated end on each shift direction.
    assign shr_in = rot ? q[0]       : sin_r;
    assign shl_in = rot ? q[WIDTH-1] : sin_l;

    // Next-state selection: clr beats en, en beats mode.
    always_comb begin
        q_nxt = q;
        if (clr) begin
            q_nxt = '0;
        end else if (en) begin
            case (mode)
                MODE_HOLD: q_nxt = q;
                MODE_SHR:  q_nxt = {shr_in, q[WIDTH-1:1]};
                MODE_SHL:  q_nxt = {q[WIDTH-2:0], shl_in};
                MODE_LOAD: q_nxt = d;
                default:   q_nxt = q;
            endcase
        end
    end

    // Storage cells.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else begin
            q <= q_nxt;
        end
    end

    // Serial outputs come straight from q so chained instances add no latency.
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed and randomised checks of univ_shift_reg at WIDTH 8, 2 and 32.
module tb_univ_shift_reg;

    localparam logic [7:0]  RV8  = 8'hA5;
    localparam logic [1:0]  RV2  = 2'b10;
    localparam logic [31:0] RV32 = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        en;
    logic [1:0]  mode;
    logic        rot;
    logic        sin_r;
    logic        sin_l;
    logic [31:0] d32;

    logic [7:0]  q8;
    logic [1:0]  q2;
    logic [31:0] q32;
    logic        sr8, sl8, sr2, sl2, sr32, sl32;

    int checks = 0;
    int errors = 0;

    logic [31:0] m8, m2, m32;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .RST_VAL(RV8)) dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode), .rot(rot),
        .sin_r(sin_r), .sin_l(sin_l), .d(d32[7:0]), .q(q8),
        .sout_r(sr8), .sout_l(sl8)
    );

    univ_shift_reg #(.WIDTH(2), .RST_VAL(RV2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode), .rot(rot),
        .sin_r(sin_r), .sin_l(sin_l), .d(d32[1:0]), .q(q2),
        .sout_r(sr2), .sout_l(sl2)
    );

    univ_shift_reg #(.WIDTH(32), .RST_VAL(RV32)) dut32 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode), .rot(rot),
        .sin_r(sin_r), .sin_l(sin_l), .d(d32), .q(q32),
        .sout_r(sr32), .sout_l(sl32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour of one clock edge for a w-bit register (rst_n high).
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input int unsigned w,
                                             input logic c, input logic e, input logic [1:0] m,
                                             input logic r, input logic sr, input logic sl,
                                             input logic [31:0] dd);
        logic [31:0] mask;
        logic [31:0] res;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        res  = cur;
        if (c) begin
            res = 32'h0;
        end else if (e) begin
            case (m)
                2'b01: begin
                    res = cur >> 1;
                    res[w-1] = r ? cur[0] : sr;
                end
                2'b10: begin
                    res = (cur << 1) & mask;
                    res[0] = r ? cur[w-1] : sl;
                end
                2'b11: res = dd & mask;
                default: res = cur;
            endcase
        end
        return res;
    endfunction

    task automatic check_models();
        check("rnd_q8",    32'(q8),   m8);
        check("rnd_q2",    32'(q2),   m2);
        check("rnd_q32",   q32,       m32);
        check("rnd_sr8",   32'(sr8),  32'(m8[0]));
        check("rnd_sl8",   32'(sl8),  32'(m8[7]));
        check("rnd_sr2",   32'(sr2),  32'(m2[0]));
        check("rnd_sl2",   32'(sl2),  32'(m2[1]));
        check("rnd_sr32",  32'(sr32), 32'(m32[0]));
        check("rnd_sl32",  32'(sl32), 32'(m32[31]));
    endtask

    initial begin
        rst_n = 1'b1; clr = 1'b0; en = 1'b0; mode = 2'b00;
        rot = 1'b0; sin_r = 1'b0; sin_l = 1'b0; d32 = 32'h0;

        // Async reset between edges takes effect at once.
        #2 rst_n = 1'b0;
        #1;
        check("rst_q",      32'(q8),  32'hA5);
        check("rst_sout_r", 32'(sr8), 32'h1);
        check("rst_sout_l", 32'(sl8), 32'h1);
        check("rst_q32",    q32,      RV32);
        check("rst_q2",     32'(q2),  32'h2);

        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_after_rst", 32'(q8), 32'hA5);
        end

        // Load then right shift with sin_r=1.
        mode = 2'b11; d32 = 32'h96;
        step();
        check("load_96", 32'(q8), 32'h96);
        mode = 2'b01; rot = 1'b0; sin_r = 1'b1;
        check("shr_sout_r0", 32'(sr8), 32'h0);
        step(); check("shr_1", 32'(q8), 32'hCB);
        check("shr_sout_r1", 32'(sr8), 32'h1);
        step(); check("shr_2", 32'(q8), 32'hE5);
        check("shr_sout_r2", 32'(sr8), 32'h1);
        step(); check("shr_3", 32'(q8), 32'hF2);
        check("shr_sout_r3", 32'(sr8), 32'h0);
        step(); check("shr_4", 32'(q8), 32'hF9);
        check("shr_sout_r4", 32'(sr8), 32'h1);
        step(); check("shr_5", 32'(q8), 32'hFC);

        // Left rotate of 8'h81 returns home after 8 edges.
        mode = 2'b11; d32 = 32'h81; rot = 1'b0;
        step();
        check("load_81", 32'(q8), 32'h81);
        check("rotl_sout_l", 32'(sl8), 32'h1);
        mode = 2'b10; rot = 1'b1; sin_l = 1'b0;
        step(); check("rotl_1", 32'(q8), 32'h03);
        step(); check("rotl_2", 32'(q8), 32'h06);
        step(); check("rotl_3", 32'(q8), 32'h0C);
        step(); check("rotl_4", 32'(q8), 32'h18);
        step(); check("rotl_5", 32'(q8), 32'h30);
        step(); check("rotl_6", 32'(q8), 32'h60);
        step(); check("rotl_7", 32'(q8), 32'hC0);
        step(); check("rotl_8", 32'(q8), 32'h81);

        // Priority: clr beats en=0 and load; en=0 then holds.
        rot = 1'b0; mode = 2'b11; d32 = 32'h3C;
        step();
        check("load_3c", 32'(q8), 32'h3C);
        clr = 1'b1; en = 1'b0; mode = 2'b11; d32 = 32'hFF;
        step();
        check("clr_prio", 32'(q8), 32'h00);
        clr = 1'b0;
        step();
        check("en0_hold_zero", 32'(q8), 32'h00);
        en = 1'b1; d32 = 32'h5A;
        step();
        check("load_5a", 32'(q8), 32'h5A);
        en = 1'b0; mode = 2'b01;
        step();
        check("en0_hold_shift", 32'(q8), 32'h5A);

        // Glitches on inputs between edges have no effect.
        en = 1'b1; mode = 2'b00;
        #2 mode = 2'b11; d32 = 32'h00;
        #2 mode = 2'b00;
        step();
        check("between_edges", 32'(q8), 32'h5A);

        // Reset pulse mid left-shift sequence.
        mode = 2'b11; d32 = 32'h0F;
        step();
        mode = 2'b10; rot = 1'b0; sin_l = 1'b1;
        step();
        check("shl_before_rst", 32'(q8), 32'h1F);
        #3 rst_n = 1'b0;
        #1;
        check("midop_rst", 32'(q8), 32'hA5);
        #1 rst_n = 1'b1;
        step();
        check("after_midop_rst", 32'(q8), 32'h4B);

        // Right rotate.
        mode = 2'b01; rot = 1'b1;
        step();
        check("rotr_1", 32'(q8), 32'hA5);

        // Random sweep across all three widths against the reference model.
        @(negedge clk);
        rst_n = 1'b0; clr = 1'b0; en = 1'b0;
        m8 = 32'(RV8); m2 = 32'(RV2); m32 = RV32;
        @(posedge clk);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            check_models();
            rst_n = ($urandom_range(0, 15) != 0);
            clr   = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 5) != 0);
            mode  = 2'($urandom_range(0, 3));
            rot   = 1'($urandom_range(0, 1));
            sin_r = 1'($urandom_range(0, 1));
            sin_l = 1'($urandom_range(0, 1));
            d32   = $urandom();
            if (!rst_n) begin
                m8 = 32'(RV8); m2 = 32'(RV2); m32 = RV32;
                #1;
                check("rnd_async_q8",  32'(q8), m8);
                check("rnd_async_q2",  32'(q2), m2);
                check("rnd_async_q32", q32,     m32);
            end
            @(posedge clk);
            if (rst_n) begin
                m8  = ref_next(m8,  8,  clr, en, mode, rot, sin_r, sin_l, d32);
                m2  = ref_next(m2,  2,  clr, en, mode, rot, sin_r, sin_l, d32);
                m32 = ref_next(m32, 32, clr, en, mode, rot, sin_r, sin_l, d32);
            end
        end
        @(negedge clk);
        check_models();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
